// File: rtl/rst_release_seq.sv
// Reset sequencer for one clock domain.
// Raw reset is asserted asynchronously and released synchronously through a
// SYNC_STAGES-deep chain, then o_rst is held for HOLD_CYCLES more edges. A level
// software reset request re-enters the hold phase without re-running the chain.
// Optional feature macro: RST_RELEASE_SEQ_CAUSE_EN adds o_cause (last reset source).
`timescale 1ns/1ps

module rst_release_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw_rst,
  output logic       o_rst,
  output logic       o_rstn,
  output logic       o_busy,
  output logic       o_rst_done
`ifdef RST_RELEASE_SEQ_CAUSE_EN
  ,
  output logic [1:0] o_cause
`endif
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StSync,
    StHold,
    StRun
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rst_q;
  logic                   busy_q;
  logic                   done_q;

  // Release chain, state machine, hold counter and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= '0;
      state_q <= StSync;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // Chain keeps filling with ones; only its MSB in StSync matters.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      done_q <= 1'b0;
      unique case (state_q)
        StSync: begin
          // Software requests are ignored until the raw release has settled.
          if (sync_q[SYNC_STAGES-1]) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (i_sw_rst) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= StRun;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (i_sw_rst) begin
            state_q <= StHold;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StSync;
          rst_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef RST_RELEASE_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  // Source of the most recent reset event; held until the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cause_q <= 2'b01;
    end else if (state_q == StRun && i_sw_rst) begin
      cause_q <= 2'b10;
    end
  end

  assign o_cause = cause_q;
`endif

  assign o_rst      = rst_q;
  assign o_rstn     = ~rst_q;
  assign o_busy     = busy_q;
  assign o_rst_done = done_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Self-checking bench for rst_release_seq (defaults SYNC_STAGES=2, HOLD_CYCLES=4).
// Expected per-cycle output words {o_rst, o_rstn, o_busy, o_rst_done} are queued when
// stimulus is applied and popped at each falling edge.
`timescale 1ns/1ps

module tb_rst_release_seq;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic sw_rst = 1'b0;
  logic o_rst, o_rstn, o_busy, o_rst_done;
`ifdef RST_RELEASE_SEQ_CAUSE_EN
  logic [1:0] o_cause;
`endif

  int total = 0;
  int bad   = 0;

  // Output word encodings {o_rst, o_rstn, o_busy, o_rst_done}.
  localparam logic [3:0] W_BUSY = 4'b1010;
  localparam logic [3:0] W_DONE = 4'b0101;
  localparam logic [3:0] W_IDLE = 4'b0100;

  logic [3:0] exp_q[$];
  wire  [3:0] obs = {o_rst, o_rstn, o_busy, o_rst_done};

  rst_release_seq #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sw_rst  (sw_rst),
    .o_rst     (o_rst),
    .o_rstn    (o_rstn),
    .o_busy    (o_busy),
    .o_rst_done(o_rst_done)
`ifdef RST_RELEASE_SEQ_CAUSE_EN
    ,
    .o_cause   (o_cause)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle and land on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release n edges from now: n-1 busy cycles, one done cycle, then idle cycles.
  function automatic void push_release(int n, int tail);
    for (int i = 1; i < n; i++) exp_q.push_back(W_BUSY);
    exp_q.push_back(W_DONE);
    for (int i = 0; i < tail; i++) exp_q.push_back(W_IDLE);
  endfunction

  task automatic test_reset();
    logic [3:0] e;
    int c;
    #1 rst = 1'b1;
    #1;
    total++;
    if (obs !== W_BUSY) begin
      bad++;
      $display("FAIL reset_async got %b want %b", obs, W_BUSY);
    end
    repeat (4) begin
      step();
      total++;
      if (obs !== W_BUSY) begin
        bad++;
        $display("FAIL reset_held got %b want %b", obs, W_BUSY);
      end
    end
    rst = 1'b0;
    push_release(7, 2);
    c = 1;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_release edge %0d got %b want %b", c, obs, e);
      end
      c++;
    end
`ifdef RST_RELEASE_SEQ_CAUSE_EN
    total++;
    if (o_cause !== 2'b01) begin
      bad++;
      $display("FAIL reset_cause got %b want 01", o_cause);
    end
`endif
  endtask

  task automatic test_sw_rst();
    logic [3:0] e;
    int i;
    sw_rst = 1'b1;
    push_release(5, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      if (i == 0) sw_rst = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sw_rst edge k+%0d got %b want %b", i, obs, e);
      end
      i++;
    end
`ifdef RST_RELEASE_SEQ_CAUSE_EN
    total++;
    if (o_cause !== 2'b10) begin
      bad++;
      $display("FAIL sw_cause got %b want 10", o_cause);
    end
`endif
  endtask

  // Short async pulse landing in the o_rst_done cycle of a sw-reset release.
  task automatic test_async_pulse();
    logic [3:0] e;
    int i;
    sw_rst = 1'b1;
    push_release(5, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      if (i == 0) sw_rst = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL pulse_pre edge k+%0d got %b want %b", i, obs, e);
      end
      i++;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (obs !== W_BUSY) begin
      bad++;
      $display("FAIL pulse_async got %b want %b", obs, W_BUSY);
    end
    #1 rst = 1'b0;
    push_release(7, 2);
    i = 1;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL pulse_release edge %0d got %b want %b", i, obs, e);
      end
      i++;
    end
`ifdef RST_RELEASE_SEQ_CAUSE_EN
    total++;
    if (o_cause !== 2'b01) begin
      bad++;
      $display("FAIL pulse_cause got %b want 01", o_cause);
    end
`endif
  endtask

  // Requests at edges k, k+2, k+3: hold restarts, release at k+7.
  task automatic test_sw_restart();
    logic [3:0] e;
    int i;
    push_release(8, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      sw_rst = (i == 0 || i == 2 || i == 3);
      step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sw_restart edge k+%0d got %b want %b", i, obs, e);
      end
      i++;
    end
    sw_rst = 1'b0;
  endtask

  // Both resets high; i_rst released first while sw stays high through S_SYNC.
  task automatic test_both();
    logic [3:0] e;
    int i;
    rst    = 1'b1;
    sw_rst = 1'b1;
    #1;
    total++;
    if (obs !== W_BUSY) begin
      bad++;
      $display("FAIL both_async got %b want %b", obs, W_BUSY);
    end
    step();
    step();
    rst = 1'b0;
    push_release(7, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      sw_rst = (i < 3);
      step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL both_release edge %0d got %b want %b", i + 1, obs, e);
      end
      i++;
    end
    sw_rst = 1'b0;
`ifdef RST_RELEASE_SEQ_CAUSE_EN
    total++;
    if (o_cause !== 2'b01) begin
      bad++;
      $display("FAIL both_cause got %b want 01", o_cause);
    end
`endif
  endtask

  // Random async pulses and sw requests; invariants checked 1 ns after each edge.
  task automatic test_random();
    logic prev_rst;
    logic want_done;
    int unsigned off;
    @(posedge clk);
    #1 prev_rst = o_rst;
    for (int c = 0; c < 100; c++) begin
      off = $urandom_range(1, 6);
      #(off);
      sw_rst = ($urandom_range(0, 6) == 0);
      rst    = ($urandom_range(0, 11) == 0);
      off = $urandom_range(1, 2);
      #(off);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (o_rstn !== ~o_rst) begin
        bad++;
        $display("FAIL rand_rstn cyc %0d got %b want %b", c, o_rstn, ~o_rst);
      end
      total++;
      if (o_busy !== o_rst) begin
        bad++;
        $display("FAIL rand_busy cyc %0d got %b want %b", c, o_busy, o_rst);
      end
      want_done = prev_rst & ~o_rst;
      total++;
      if (o_rst_done !== want_done) begin
        bad++;
        $display("FAIL rand_done cyc %0d got %b want %b", c, o_rst_done, want_done);
      end
      prev_rst = o_rst;
    end
    sw_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw_rst();
    test_async_pulse();
    test_sw_restart();
    test_both();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
